// File: rtl/pc_next_unit.sv
// Registered next-PC generator: normal source mux, trap entry (direct/vectored MTVEC),
// trap return (MEPC) and stall-time trap latching. Define PC_VECTORED_EN to enable vectored interrupts.
module pc_next_unit #(
    parameter int              WIDTH    = 32,
    parameter int              NSRC     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSRC*WIDTH-1:0]    src,
    input  logic [$clog2(NSRC)-1:0]  sel,
    input  logic                     pc_we,
    input  logic                     trap_req,
    input  logic                     trap_intr,
    input  logic [4:0]               trap_cause,
    input  logic                     mret,
    input  logic [WIDTH-1:0]         mtvec,
    input  logic [WIDTH-1:0]         mepc,
    output logic [WIDTH-1:0]         pc,
    output logic                     trap_taken,
    output logic [WIDTH-1:0]         epc_out,
    output logic [5:0]               cause_out,
    output logic                     pending
);

    localparam int SW = $clog2(NSRC);

    typedef enum logic {RUN, TRAP_PEND} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] pc_d, epc_d, src_pc, trap_target, base;
    logic [5:0]       cause_d;
    logic             taken_d;
    logic             pend_intr, pend_intr_d;
    logic [4:0]       pend_cause, pend_cause_d;
    logic             take, use_intr;
    logic [4:0]       use_cause;

    // Out-of-range selects fall back to source 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        src_pc = src[0 +: WIDTH];
        for (int i = 1; i < NSRC; i++) begin
            if (sel == SW'(i)) src_pc = src[i*WIDTH +: WIDTH];
        end
    end

    // A pending trap always commits with the cause captured when it was first raised.
    assign use_intr  = (state == TRAP_PEND) ? pend_intr  : trap_intr;
    assign use_cause = (state == TRAP_PEND) ? pend_cause : trap_cause;
    assign base      = {mtvec[WIDTH-1:2], 2'b00};

`ifdef PC_VECTORED_EN
    logic [WIDTH-1:0] vec_off;
    assign vec_off     = {{(WIDTH-7){1'b0}}, use_cause, 2'b00};
    assign trap_target = (mtvec[1:0] == 2'b01 && use_intr) ? base + vec_off : base;
`else
    assign trap_target = base;
`endif

    assign take = pc_we && (state == TRAP_PEND || trap_req);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) state <= RUN;
        else        state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            RUN:       if (!pc_we && trap_req) state_d = TRAP_PEND;
            TRAP_PEND: if (pc_we)              state_d = RUN;
            default:                           state_d = RUN;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        pc_d         = pc;
        epc_d        = epc_out;
        cause_d      = cause_out;
        taken_d      = 1'b0;
        pend_intr_d  = pend_intr;
        pend_cause_d = pend_cause;
        if (take) begin
            pc_d    = trap_target;
            epc_d   = pc;
            cause_d = {use_intr, use_cause};
            taken_d = 1'b1;
        end else if (pc_we && mret) begin
            pc_d = {mepc[WIDTH-1:2], 2'b00};
        end else if (pc_we) begin
            pc_d = src_pc;
        end
        if (state == RUN && !pc_we && trap_req) begin
            pend_intr_d  = trap_intr;
            pend_cause_d = trap_cause;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            epc_out    <= '0;
            cause_out  <= '0;
            trap_taken <= 1'b0;
            pend_intr  <= 1'b0;
            pend_cause <= '0;
        end else begin
            pc         <= pc_d;
            epc_out    <= epc_d;
            cause_out  <= cause_d;
            trap_taken <= taken_d;
            pend_intr  <= pend_intr_d;
            pend_cause <= pend_cause_d;
        end
    end

    assign pending = (state == TRAP_PEND);

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the PC/trap rules.
module tb_pc_next_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*W-1:0] src;
    logic [1:0]     sel;
    logic           pc_we, trap_req, trap_intr, mret;
    logic [4:0]     trap_cause;
    logic [W-1:0]   mtvec, mepc;
    logic [W-1:0]   pc, epc_out;
    logic           trap_taken, pending;
    logic [5:0]     cause_out;

    logic [3*W-1:0] src3;
    logic [1:0]     sel3;
    logic [W-1:0]   pc3, epc3;
    logic           taken3, pend3;
    logic [5:0]     cause3;

    int tests = 0;
    int fails = 0;

    // Behavioural model state.
    logic [W-1:0] m_pc, m_epc;
    logic [5:0]   m_cause;
    logic         m_taken, m_pend, m_pintr;
    logic [4:0]   m_pcause;

    always #5 clk = ~clk;

    pc_next_unit #(.WIDTH(W), .NSRC(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .src(src), .sel(sel), .pc_we(pc_we),
        .trap_req(trap_req), .trap_intr(trap_intr), .trap_cause(trap_cause),
        .mret(mret), .mtvec(mtvec), .mepc(mepc), .pc(pc), .trap_taken(trap_taken),
        .epc_out(epc_out), .cause_out(cause_out), .pending(pending)
    );

    pc_next_unit #(.WIDTH(W), .NSRC(3), .RESET_PC(32'h0)) dut3 (
        .clk(clk), .rst_n(rst_n), .src(src3), .sel(sel3), .pc_we(pc_we),
        .trap_req(trap_req), .trap_intr(trap_intr), .trap_cause(trap_cause),
        .mret(mret), .mtvec(mtvec), .mepc(mepc), .pc(pc3), .trap_taken(taken3),
        .epc_out(epc3), .cause_out(cause3), .pending(pend3)
    );

    function automatic logic [W-1:0] target(input logic [W-1:0] tv, input logic intr,
                                            input logic [4:0] cause);
        logic [W-1:0] b;
        b = tv & ~32'h3;
`ifdef PC_VECTORED_EN
        if (tv[1:0] == 2'b01 && intr) return b + 32'(cause) * 4;
`endif
        return b;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_cause = 6'h0;
        m_taken = 1'b0; m_pend = 1'b0; m_pintr = 1'b0; m_pcause = 5'h0;
    endtask

    task automatic model_take(input logic intr, input logic [4:0] cause);
        m_epc   = m_pc;
        m_pc    = target(mtvec, intr, cause);
        m_cause = {intr, cause};
        m_taken = 1'b1;
    endtask

    task automatic model_update();
        m_taken = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_pend) begin
            if (pc_we) begin
                model_take(m_pintr, m_pcause);
                m_pend = 1'b0;
            end
        end else if (pc_we) begin
            if (trap_req)  model_take(trap_intr, trap_cause);
            else if (mret) m_pc = mepc & ~32'h3;
            else           m_pc = src[int'(sel)*W +: W];
        end else if (trap_req) begin
            m_pend = 1'b1; m_pintr = trap_intr; m_pcause = trap_cause;
        end
    endtask

    // Inputs change on the falling edge; model advances on the rising edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pc_we = 1'b0; trap_req = 1'b0; mret = 1'b0; trap_intr = 1'b0; trap_cause = 5'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; idle_inputs(); pc_we = 1'b1;
        src = '0; src[2*W +: W] = 32'h100; sel = 2'd2;
        src3 = '0; sel3 = 2'd0; mtvec = 32'h0; mepc = 32'h0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({pc, trap_taken, epc_out, cause_out, pending} !== {32'h0, 1'b0, 32'h0, 6'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: pc=%h taken=%b epc=%h cause=%h pend=%b, required all zero",
                     pc, trap_taken, epc_out, cause_out, pending);
        end
        @(negedge clk);
        step();
        tests++;
        if (pc !== 32'h0) begin
            fails++; $display("FAIL reset_hold: pc=%h required 0", pc);
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (pc !== 32'h100 || pc !== m_pc) begin
            fails++; $display("FAIL reset_release: pc=%h required 00000100", pc);
        end
    endtask

    task automatic test_trap_vectored();
        idle_inputs(); pc_we = 1'b1; src[0 +: W] = 32'h200; sel = 2'd0;
        step();
        mtvec = 32'h8000_0001; trap_req = 1'b1; trap_intr = 1'b1; trap_cause = 5'd7;
        step();
        tests++;
        if (pc !== m_pc || epc_out !== 32'h200 || cause_out !== 6'h27 || trap_taken !== 1'b1) begin
            fails++;
            $display("FAIL trap_entry: pc=%h epc=%h cause=%h taken=%b, required pc=%h epc=00000200 cause=27 taken=1",
                     pc, epc_out, cause_out, trap_taken, m_pc);
        end
`ifdef PC_VECTORED_EN
        tests++;
        if (pc !== 32'h8000_001C) begin fails++; $display("FAIL trap_vector: pc=%h required 8000001c", pc); end
`else
        tests++;
        if (pc !== 32'h8000_0000) begin fails++; $display("FAIL trap_direct: pc=%h required 80000000", pc); end
`endif
        idle_inputs();
        step();
        tests++;
        if (trap_taken !== 1'b0 || pc !== m_pc || cause_out !== 6'h27) begin
            fails++;
            $display("FAIL trap_pulse: taken=%b pc=%h cause=%h, required taken=0 pc=%h cause=27",
                     trap_taken, pc, cause_out, m_pc);
        end
    endtask

    task automatic test_pending();
        logic [W-1:0] held;
        idle_inputs(); mtvec = 32'h1000_0001;
        held = m_pc;
        trap_req = 1'b1; trap_cause = 5'd2;
        step();
        trap_cause = 5'd5;
        step();
        trap_req = 1'b0; mret = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (pending !== 1'b1 || pc !== held || trap_taken !== 1'b0) begin
                fails++;
                $display("FAIL pend_hold[%0d]: pend=%b pc=%h taken=%b, required pend=1 pc=%h taken=0",
                         i, pending, pc, trap_taken, held);
            end
        end
        pc_we = 1'b1; sel = 2'd1; src[W +: W] = 32'h4444_0000;
        step();
        tests++;
        if (pc !== 32'h1000_0000 || cause_out !== 6'h02 || pending !== 1'b0 || trap_taken !== 1'b1
            || epc_out !== held || pc !== m_pc) begin
            fails++;
            $display("FAIL pend_take: pc=%h cause=%h pend=%b taken=%b epc=%h, required pc=10000000 cause=02 pend=0 taken=1 epc=%h",
                     pc, cause_out, pending, trap_taken, epc_out, held);
        end
    endtask

    task automatic test_trap_mret();
        idle_inputs(); pc_we = 1'b1; mtvec = 32'h0000_3000; mepc = 32'h304;
        trap_req = 1'b1; mret = 1'b1; trap_cause = 5'd11;
        step();
        tests++;
        if (pc !== 32'h3000 || trap_taken !== 1'b1 || pc !== m_pc) begin
            fails++; $display("FAIL trap_over_mret: pc=%h taken=%b, required pc=00003000 taken=1", pc, trap_taken);
        end
        trap_req = 1'b0;
        step();
        tests++;
        if (pc !== 32'h304 || trap_taken !== 1'b0) begin
            fails++; $display("FAIL mret: pc=%h taken=%b, required pc=00000304 taken=0", pc, trap_taken);
        end
    endtask

    task automatic test_wrap();
        idle_inputs(); pc_we = 1'b1; mtvec = 32'hFFFF_FFFD;
        trap_req = 1'b1; trap_intr = 1'b1; trap_cause = 5'd31;
        step();
        tests++;
`ifdef PC_VECTORED_EN
        if (pc !== 32'h0000_0078 || pc !== m_pc) begin
            fails++; $display("FAIL vector_wrap: pc=%h required 00000078", pc);
        end
`else
        if (pc !== 32'hFFFF_FFFC || pc !== m_pc) begin
            fails++; $display("FAIL direct_base: pc=%h required fffffffc", pc);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] first;
        idle_inputs(); pc_we = 1'b1; mtvec = 32'h2000_0000;
        trap_req = 1'b1; trap_cause = 5'd3;
        step();
        first = m_pc;
        mtvec = 32'h2400_0000; trap_cause = 5'd4;
        step();
        tests++;
        if (trap_taken !== 1'b1 || epc_out !== first || pc !== 32'h2400_0000 || cause_out !== 6'h04) begin
            fails++;
            $display("FAIL back_to_back: taken=%b epc=%h pc=%h cause=%h, required taken=1 epc=%h pc=24000000 cause=04",
                     trap_taken, epc_out, pc, cause_out, first);
        end
    endtask

    task automatic test_reset_mid_pend();
        idle_inputs(); trap_req = 1'b1; trap_cause = 5'd9;
        step();
        tests++;
        if (pending !== 1'b1) begin fails++; $display("FAIL pend_set: pend=%b required 1", pending); end
        trap_req = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (pending !== 1'b0 || trap_taken !== 1'b0 || pc !== 32'h0) begin
            fails++; $display("FAIL pend_reset: pend=%b taken=%b pc=%h, required 0 0 0", pending, trap_taken, pc);
        end
        @(negedge clk);
        rst_n = 1'b1; pc_we = 1'b1; sel = 2'd3; src[3*W +: W] = 32'h0000_0ABC;
        step();
        tests++;
        if (trap_taken !== 1'b0 || pc !== 32'h0ABC || cause_out !== 6'h0) begin
            fails++;
            $display("FAIL pend_discard: taken=%b pc=%h cause=%h, required taken=0 pc=00000abc cause=00",
                     trap_taken, pc, cause_out);
        end
    endtask

    task automatic test_sel_oob();
        logic [W-1:0] exp;
        idle_inputs(); pc_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) src3[k*W +: W] = $urandom();
            sel3 = (i < 2) ? 2'd3 : 2'($urandom_range(0, 3));
            if (i == 0) src3[0 +: W] = 32'h40;
            exp = (sel3 < 2'd3) ? src3[int'(sel3)*W +: W] : src3[0 +: W];
            step();
            tests++;
            if (pc3 !== exp) begin
                fails++; $display("FAIL sel_oob[%0d] sel=%0d: pc=%h required %h", i, sel3, pc3, exp);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            pc_we      = ($urandom_range(0, 3) != 0);
            trap_req   = ($urandom_range(0, 5) == 0);
            trap_intr  = 1'($urandom());
            trap_cause = 5'($urandom());
            mret       = ($urandom_range(0, 4) == 0);
            mtvec      = $urandom();
            if ($urandom_range(0, 1) == 1) mtvec[1:0] = 2'b01;
            mepc       = $urandom();
            sel        = 2'($urandom());
            for (int k = 0; k < 4; k++) src[k*W +: W] = $urandom();
            step();
            tests++;
            if ({pc, trap_taken, epc_out, cause_out, pending} !== {m_pc, m_taken, m_epc, m_cause, m_pend}) begin
                fails++;
                $display("FAIL random[%0d]: pc=%h taken=%b epc=%h cause=%h pend=%b, required pc=%h taken=%b epc=%h cause=%h pend=%b",
                         i, pc, trap_taken, epc_out, cause_out, pending,
                         m_pc, m_taken, m_epc, m_cause, m_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_trap_vectored();
        test_pending();
        test_trap_mret();
        test_wrap();
        test_back_to_back();
        test_reset_mid_pend();
        test_sel_oob();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
